// File: rtl/ls_mem_sequencer.sv
// ls_mem_sequencer: multicycle load/store sequencer with alignment trap
module ls_mem_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [1:0] addr_lsb,
    output logic [2:0] iord_sel,
    output logic       mem_wr,
    output logic       mdr_wr,
    output logic       reg_wr,
    output logic [2:0] mem_to_reg_sel,
    output logic [1:0] ls_ctrl,
    output logic [1:0] ss_ctrl,
    output logic       busy,
    output logic       done,
    output logic       misaligned
);
    typedef enum logic [2:0] {IDLE, ADDR, RDWAIT, MDR, WB, WRITE, EXC, DONE} state_t;
    state_t     state;
    logic [2:0] op_q;
    logic [1:0] cnt;
    logic       bad;
    logic [1:0] sz;
    if (MEM_WAIT < 1 || MEM_WAIT > 3) begin : g_bad_wait
        $error("MEM_WAIT must be 1..3");
    end
    // illegal codes and word/half accesses off their natural boundary trap immediately
    assign bad = op > 3'd5
               || ((op == 3'd0 || op == 3'd3) && addr_lsb != 2'b00)
               || ((op == 3'd1 || op == 3'd4) && addr_lsb[0]);
    assign sz = (op_q == 3'd0 || op_q == 3'd3) ? 2'b01
              : (op_q == 3'd1 || op_q == 3'd4) ? 2'b10 : 2'b11;
    // sequence state, captured op and read-latency counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= 3'd0;
            cnt   <= 2'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    state <= bad ? EXC : ADDR;
                end
                ADDR: if (op_q == 3'd3) state <= WRITE;
                      else begin
                          cnt   <= 2'(MEM_WAIT - 1);
                          state <= RDWAIT;
                      end
                RDWAIT: if (cnt == 2'd0) state <= MDR;
                        else cnt <= cnt - 2'd1;
                MDR:    state <= (op_q < 3'd3) ? WB : WRITE;
                WB, WRITE, EXC: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
    assign busy           = state != IDLE;
    assign iord_sel       = (state == ADDR || state == RDWAIT || state == MDR || state == WRITE) ? 3'b001
                          : (state == EXC) ? 3'b010 : 3'b000;
    assign mem_wr         = state == WRITE;
    assign mdr_wr         = state == MDR;
    assign reg_wr         = state == WB;
    assign mem_to_reg_sel = (state == WB) ? 3'b001 : 3'b000;
    assign ls_ctrl        = (state == WB) ? sz : 2'b00;
    assign ss_ctrl        = (state == WRITE) ? sz : 2'b00;
    assign done           = state == DONE;
    assign misaligned     = state == EXC;
endmodule

// File: tb/tb_ls_mem_sequencer.sv
// tb_ls_mem_sequencer: directed table, corner sequences and random ops vs a timing model
module tb_ls_mem_sequencer;
    localparam int MW = 2;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  addr_lsb = 2'd0;
    logic [2:0]  iord_sel, mem_to_reg_sel;
    logic        mem_wr, mdr_wr, reg_wr, busy, done, misaligned;
    logic [1:0]  ls_ctrl, ss_ctrl;
    logic [15:0] act;
    logic [15:0] exp_tr [0:15];
    int          checks = 0;
    int          passed = 0;

    typedef struct {
        logic [2:0] op;
        logic [1:0] lsb;
        int         done_c;
        int         mdr_c;
        int         memwr_c;
        int         reg_c;
        int         exc_c;
        logic [1:0] sz;
        string      name;
    } vec_t;
    vec_t tbl [8];

    ls_mem_sequencer #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr_lsb(addr_lsb),
        .iord_sel(iord_sel), .mem_wr(mem_wr), .mdr_wr(mdr_wr), .reg_wr(reg_wr),
        .mem_to_reg_sel(mem_to_reg_sel), .ls_ctrl(ls_ctrl), .ss_ctrl(ss_ctrl),
        .busy(busy), .done(done), .misaligned(misaligned)
    );

    assign act = {iord_sel, mem_wr, mdr_wr, reg_wr, mem_to_reg_sel, ls_ctrl, ss_ctrl, busy, done, misaligned};

    always #5 clk = ~clk;

    task automatic chk(input string name, input int c, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a === e) passed++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, c, a, e);
    endtask

    function automatic bit is_exc(int o, int l);
        return o > 5 || (o % 3 == 0 && l != 0) || (o % 3 == 1 && l % 2 == 1);
    endfunction

    function automatic int mlen(int o, int l);
        return is_exc(o, l) ? 2 : (o == 3) ? 3 : MW + 4;
    endfunction

    function automatic logic [15:0] model(int o, int l, int c);
        int n;
        bit ex, ld, wr, md, rw, ia;
        logic [2:0] io;
        logic [1:0] sz;
        n  = mlen(o, l);
        ex = is_exc(o, l);
        ld = !ex && o < 3;
        sz = 2'(o % 3 + 1);
        ia = (o == 3) ? c <= 2 : ld ? c <= MW + 2 : c <= MW + 3;
        io = ex ? (c == 1 ? 3'd2 : 3'd0) : (ia ? 3'd1 : 3'd0);
        md = !ex && o != 3 && c == MW + 2;
        rw = ld && c == MW + 3;
        wr = !ex && ((o == 3) ? c == 2 : (!ld && c == MW + 3));
        return {io, wr, md, rw, rw ? 3'd1 : 3'd0, rw ? sz : 2'd0, wr ? sz : 2'd0,
                c <= n, c == n, ex && c == 1};
    endfunction

    task automatic run(input logic [2:0] o, input logic [1:0] l, input int len, input bit noisy, input string name);
        @(negedge clk);
        start = 1'b1; op = o; addr_lsb = l;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            chk(name, c, act, exp_tr[c]);
            start = (noisy && c < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            op = 3'($urandom);
            addr_lsb = 2'($urandom);
        end
    endtask

    initial begin
        tbl[0] = '{3'd0, 2'd0, 6, 4, 0, 5, 0, 2'd1, "lw00"};
        tbl[1] = '{3'd5, 2'd3, 6, 4, 5, 0, 0, 2'd3, "sb11"};
        tbl[2] = '{3'd3, 2'd0, 3, 0, 2, 0, 0, 2'd1, "sw00"};
        tbl[3] = '{3'd1, 2'd1, 2, 0, 0, 0, 1, 2'd0, "lh01"};
        tbl[4] = '{3'd0, 2'd2, 2, 0, 0, 0, 1, 2'd0, "lw10"};
        tbl[5] = '{3'd7, 2'd0, 2, 0, 0, 0, 1, 2'd0, "op7"};
        tbl[6] = '{3'd2, 2'd3, 6, 4, 0, 5, 0, 2'd3, "lb11"};
        tbl[7] = '{3'd4, 2'd2, 6, 4, 5, 0, 0, 2'd2, "sh10"};

        @(negedge clk);
        chk("reset_state", 0, act, 16'h0);
        reset = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("idle_after_reset", k, act, 16'h0);
        end

        foreach (tbl[i]) begin
            for (int c = 1; c <= tbl[i].done_c + 1; c++) begin
                logic [2:0] io;
                logic mw, rw;
                io = (c == tbl[i].exc_c) ? 3'd2
                   : (tbl[i].exc_c == 0 && c < tbl[i].done_c && c != tbl[i].reg_c) ? 3'd1 : 3'd0;
                mw = c == tbl[i].memwr_c;
                rw = c == tbl[i].reg_c;
                exp_tr[c] = {io, mw, c == tbl[i].mdr_c, rw, rw ? 3'd1 : 3'd0,
                             rw ? tbl[i].sz : 2'd0, mw ? tbl[i].sz : 2'd0,
                             c <= tbl[i].done_c, c == tbl[i].done_c, c == tbl[i].exc_c};
            end
            run(tbl[i].op, tbl[i].lsb, tbl[i].done_c, 1'b0, tbl[i].name);
        end

        @(negedge clk);
        start = 1'b1; op = 3'd0; addr_lsb = 2'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("reset_async_rdwait", 2, act, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("idle_after_mid_reset", k, act, 16'h0);
        end

        @(negedge clk);
        start = 1'b1; op = 3'd3; addr_lsb = 2'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("sw_write_before_reset", 2, {15'd0, mem_wr}, 16'd1);
        #2 reset = 1'b1;
        #1 chk("reset_async_write", 2, act, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("no_write_after_reset", k, act, 16'h0);
        end

        @(negedge clk);
        start = 1'b1; op = 3'd3; addr_lsb = 2'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("held_start_done", k, {15'd0, done}, {15'd0, k % 4 == 3});
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        for (int r = 0; r < 40; r++) begin
            int o, l, n;
            o = $urandom_range(0, 7);
            l = $urandom_range(0, 3);
            n = mlen(o, l);
            for (int c = 1; c <= n + 1; c++) exp_tr[c] = model(o, l, c);
            run(3'(o), 2'(l), n, 1'b1, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
